// File: rtl/mem_stage_pkg.sv
// Shared state encoding and default sizing for the memory pipeline stage.
package mem_stage_pkg;

  localparam int unsigned ADDR_W_DEF      = 8;
  localparam int unsigned DATA_W_DEF      = 64;
  localparam int unsigned TIMEOUT_CYC_DEF = 15;
  localparam int unsigned WREG_W          = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_stage_timer.sv
// Wait counter for a memory access: cleared when a request starts, counts REQ/RWAIT cycles,
// and flags the cycle on which the access has used up its allowed time.
module mem_stage_timer
  import mem_stage_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at LIMIT so a late grant on the last cycle cannot wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one load/store per EX/M op over a req/gnt/rvalid port and stalls until done.
// Optional feature: define MEM_STAGE_PERF_CNT_EN to add the 32-bit stall_cnt performance counter.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WRegEn_M,
  input  logic              WMemEn_M,
  input  logic [ADDR_W-1:0] R1_out_M,
  input  logic [DATA_W-1:0] R2_out_M,
  input  logic [WREG_W-1:0] WReg1_M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_M,
  output logic              WRegEn_WB,
  output logic [WREG_W-1:0] WReg1_WB,
  output logic [DATA_W-1:0] WData_WB,
  output logic              err_o
`ifdef MEM_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  state_e            state_q;
  logic              store_q;
  logic [WREG_W-1:0] dest_q;
  logic              op_c;
  logic              timer_clr_c;
  logic              timer_en_c;
  logic              expired;

  assign op_c        = WRegEn_M | WMemEn_M;
  assign timer_clr_c = (state_q == IDLE) && op_c;
  assign timer_en_c  = (state_q == REQ) || (state_q == RWAIT);
  assign stall_M     = op_c && (state_q != DONE);

  mem_stage_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clr_c),
    .enable  (timer_en_c),
    .expired (expired)
  );

  // A handshake in the expiry cycle takes priority over the abort path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      dest_q     <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      WRegEn_WB  <= 1'b0;
      WReg1_WB   <= '0;
      WData_WB   <= '0;
      err_o      <= 1'b0;
    end else begin
      WRegEn_WB <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_c) begin
            store_q    <= WMemEn_M;
            dest_q     <= WReg1_M;
            dmem_addr  <= R1_out_M;
            dmem_wdata <= R2_out_M;
            dmem_req   <= 1'b1;
            dmem_we    <= WMemEn_M;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (store_q) begin
              WReg1_WB <= dest_q;
              state_q  <= DONE;
            end else begin
              state_q  <= RWAIT;
            end
          end else if (expired) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            WReg1_WB <= dest_q;
            WData_WB <= '0;
            err_o    <= 1'b1;
            state_q  <= DONE;
          end
        end
        RWAIT: begin
          if (dmem_rvalid) begin
            WRegEn_WB <= 1'b1;
            WReg1_WB  <= dest_q;
            WData_WB  <= dmem_rdata;
            state_q   <= DONE;
          end else if (expired) begin
            WReg1_WB <= dest_q;
            WData_WB <= '0;
            err_o    <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_STAGE_PERF_CNT_EN
  // Stall cycle counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_M && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops against a transaction-level model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DW = DATA_W_DEF;
  localparam int          TO = int'(TIMEOUT_CYC_DEF);

  logic          clk;
  logic          rst;
  logic          WRegEn_M, WMemEn_M;
  logic [AW-1:0] R1_out_M;
  logic [DW-1:0] R2_out_M;
  logic [2:0]    WReg1_M;
  logic          dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_gnt, dmem_rvalid;
  logic [DW-1:0] dmem_rdata;
  logic          stall_M, WRegEn_WB;
  logic [2:0]    WReg1_WB;
  logic [DW-1:0] WData_WB;
  logic          err_o;
`ifdef MEM_STAGE_PERF_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_stage #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TIMEOUT_CYC_DEF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .WRegEn_M    (WRegEn_M),
    .WMemEn_M    (WMemEn_M),
    .R1_out_M    (R1_out_M),
    .R2_out_M    (R2_out_M),
    .WReg1_M     (WReg1_M),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .stall_M     (stall_M),
    .WRegEn_WB   (WRegEn_WB),
    .WReg1_WB    (WReg1_WB),
    .WData_WB    (WData_WB),
    .err_o       (err_o)
`ifdef MEM_STAGE_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  int unsigned     n_pass;
  int unsigned     n_checks;
  string           cur_op;

  // Architectural view of the stage, updated per transaction from the protocol rules.
  logic [AW-1:0]   addr_m;
  logic [DW-1:0]   wdata_m;
  logic [DW-1:0]   wb_data_m;
  logic [2:0]      wb_dest_m;
  logic            err_m;
  longint unsigned stall_cnt_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got 0x%0h expected 0x%0h (t=%0t)", cur_op, tag, got, exp, $time);
  endtask

  task automatic model_reset();
    addr_m      = '0;
    wdata_m     = '0;
    wb_data_m   = '0;
    wb_dest_m   = '0;
    err_m       = 1'b0;
    stall_cnt_m = 0;
  endtask

  // Called just after a rising edge; samples on the falling edge, returns just after the next rising edge.
  task automatic check_cycle(input logic e_stall, input logic e_req, input logic e_we, input logic e_wben);
    @(negedge clk);
    check("stall_M",    64'(stall_M),    64'(e_stall));
    check("dmem_req",   64'(dmem_req),   64'(e_req));
    check("dmem_we",    64'(dmem_we),    64'(e_we));
    check("dmem_addr",  64'(dmem_addr),  64'(addr_m));
    check("dmem_wdata", 64'(dmem_wdata), 64'(wdata_m));
    check("WRegEn_WB",  64'(WRegEn_WB),  64'(e_wben));
    check("WReg1_WB",   64'(WReg1_WB),   64'(wb_dest_m));
    check("WData_WB",   64'(WData_WB),   64'(wb_data_m));
    check("err_o",      64'(err_o),      64'(err_m));
`ifdef MEM_STAGE_PERF_CNT_EN
    check("stall_cnt",  64'(stall_cnt),  64'(stall_cnt_m));
`endif
    if (rst && e_stall) stall_cnt_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit junk);
    WRegEn_M = 1'b0;
    WMemEn_M = 1'b0;
    for (int i = 0; i < n; i++) begin
      dmem_gnt    = junk && ($urandom_range(0, 1) == 1);
      dmem_rvalid = junk && ($urandom_range(0, 1) == 1);
      dmem_rdata  = {$urandom, $urandom};
      check_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    WRegEn_M    = 1'b0;
    WMemEn_M    = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // One op: gnt in REQ cycle gd (1-based), rvalid rd cycles after gnt; rst_at >= 0 resets mid-op at that cycle.
  task automatic run_op(input string name, input logic wreg, input logic wmem,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [2:0] dest,
                        input int gd, input int rd, input logic [DW-1:0] rdata,
                        input bit noise, input int rst_at);
    int   w, kab, req_last, len;
    bit   abort;
    logic store;
    cur_op = name;
    store  = wmem;
    // Abort happens on the first wait cycle >= TO without progress; a load granted on cycle TO gets one RWAIT cycle.
    kab = (gd + 1 > TO) ? gd + 1 : TO;
    if (gd > TO) begin
      w = TO; abort = 1'b1;
    end else if (store) begin
      w = gd; abort = 1'b0;
    end else if (gd + rd <= kab) begin
      w = gd + rd; abort = 1'b0;
    end else begin
      w = kab; abort = 1'b1;
    end
    req_last = (gd < TO) ? gd : TO;
    len      = w + 2;
    WRegEn_M = wreg;
    WMemEn_M = wmem;
    R1_out_M = addr;
    R2_out_M = data;
    WReg1_M  = dest;
    for (int c = 0; c < len; c++) begin
      dmem_gnt    = (c == gd);
      dmem_rvalid = (!store && (c == gd + rd)) || (noise && (c <= gd) && ($urandom_range(0, 1) == 1));
      dmem_rdata  = (c == gd + rd) ? rdata : {$urandom, $urandom};
      if (c == 1) begin
        addr_m  = addr;
        wdata_m = data;
      end
      if (c == len - 1) begin
        wb_dest_m = dest;
        if (abort) begin
          wb_data_m = '0;
          err_m     = 1'b1;
        end else if (!store) begin
          wb_data_m = rdata;
        end
      end
      if (c == rst_at) rst = 1'b0;
      check_cycle(c < len - 1, (c >= 1) && (c <= req_last), store && (c >= 1) && (c <= req_last),
                  !store && !abort && (c == len - 1));
      if (c == rst_at) begin
        rst = 1'b1;
        model_reset();
        break;
      end
    end
    WRegEn_M    = 1'b0;
    WMemEn_M    = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    logic r_wm, r_wr;
    int   r_gd, r_rd;
    n_pass      = 0;
    n_checks    = 0;
    cur_op      = "reset";
    rst         = 1'b0;
    WRegEn_M    = 1'b0;
    WMemEn_M    = 1'b0;
    R1_out_M    = '0;
    R2_out_M    = '0;
    WReg1_M     = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2, 1'b0);

    run_op("store_basic", 1'b0, 1'b1, 8'h12, 64'hDEADBEEF_00000001, 3'd0, 1, 0, '0, 1'b0, -1);
    idle(1, 1'b0);
    run_op("load_basic", 1'b1, 1'b0, 8'h34, 64'h5555, 3'd5, 2, 3, 64'h0123, 1'b0, -1);
    idle(1, 1'b1);
    run_op("store_gnt_last", 1'b0, 1'b1, 8'hA5, 64'h77, 3'd2, TO, 0, '0, 1'b0, -1);
    run_op("load_gnt_last", 1'b1, 1'b0, 8'h5A, 64'h0, 3'd6, TO, 1, 64'hCAFE, 1'b1, -1);
    run_op("b2b_store", 1'b1, 1'b1, 8'h10, 64'h1111, 3'd1, 1, 0, '0, 1'b0, -1);
    run_op("b2b_load", 1'b1, 1'b0, 8'h11, 64'h0, 3'd4, 1, 1, 64'h2222, 1'b0, -1);
    idle(1, 1'b0);
    run_op("load_timeout", 1'b1, 1'b0, 8'h20, 64'h0, 3'd7, 99, 1, 64'hFFFF, 1'b1, -1);
    cur_op = "err_sticky";
    idle(10, 1'b1);
    run_op("load_rst_rwait", 1'b1, 1'b0, 8'h44, 64'h0, 3'd3, 1, 5, 64'h9999, 1'b0, 3);
    cur_op = "post_rst";
    idle(3, 1'b1);

    for (int i = 0; i < 40; i++) begin
      r_wm = 1'($urandom_range(0, 1));
      r_wr = r_wm ? 1'($urandom_range(0, 1)) : 1'b1;
      r_gd = int'($urandom_range(1, TO + 2));
      r_rd = int'($urandom_range(1, 6));
      if ($urandom_range(0, 7) == 0) r_rd = int'($urandom_range(7, 20));
      run_op("rand", r_wr, r_wm, AW'($urandom), {$urandom, $urandom}, 3'($urandom),
             r_gd, r_rd, {$urandom, $urandom}, 1'b1, -1);
      if ($urandom_range(0, 9) == 0) do_reset();
      cur_op = "rand_gap";
      idle(int'($urandom_range(0, 2)), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_W, default 8, shall set the data-memory address width taken from R1_out_M[7:0].
REQ-002 Parameter DATA_W, default 64, shall set the store/load data width.
REQ-003 Parameter TIMEOUT_CYC, default 15, shall set the maximum cycles spent in REQ plus RWAIT before abort.
REQ-004 The block shall have one clock and a synchronous, active-low reset; ports: clk in 1, rising-edge clock; rst in 1, synchronous active-low reset.
REQ-005 The block shall have pipeline inputs: WRegEn_M in 1, load/reg-write; WMemEn_M in 1, store; R1_out_M in ADDR_W, address; R2_out_M in DATA_W, store data; WReg1_M in 3, destination register.
REQ-006 The block shall have memory outputs: dmem_req out 1; dmem_we out 1; dmem_addr out ADDR_W; dmem_wdata out DATA_W.
REQ-007 The block shall have memory inputs: dmem_gnt in 1, request accepted; dmem_rvalid in 1, read data valid; dmem_rdata in DATA_W.
REQ-008 The block shall have stage outputs: stall_M out 1, freezes EX/M register; WRegEn_WB out 1; WReg1_WB out 3; WData_WB out DATA_W; err_o out 1, sticky timeout flag.

Function
REQ-009 An op shall be present when WRegEn_M or WMemEn_M is high; WMemEn_M high means store, else a load.
REQ-010 When both enables are high, the block shall perform the store and suppress WRegEn_WB.
REQ-011 The FSM shall have states IDLE, REQ, RWAIT, DONE.
REQ-012 IDLE with op present: capture addr/data/dest/type, go to REQ; IDLE with no op: stay IDLE, WRegEn_WB=0 next cycle.
REQ-013 In REQ, dmem_req=1, dmem_we=store, and addr/wdata shall hold the captured values until dmem_gnt.
REQ-014 REQ with dmem_gnt: a store goes to DONE, a load goes to RWAIT; dmem_req shall deassert the cycle after gnt.
REQ-015 RWAIT with dmem_rvalid: capture dmem_rdata into WData_WB, go to DONE; rvalid outside RWAIT shall be ignored.
REQ-016 DONE shall last one cycle, then go to IDLE; WRegEn_WB=1 only in DONE for a non-aborted load; WReg1_WB and WData_WB hold until the next DONE.
REQ-017 stall_M shall be combinational and equal (op present AND state != DONE); it shall be 0 in DONE so EX/M advances exactly once per op.
REQ-018 Minimum latency shall be 3 cycles (IDLE, REQ with gnt, DONE) for a store and 4 cycles for a load with rvalid one cycle after gnt.
REQ-019 A wait counter shall clear on entry to REQ and increment each cycle in REQ or RWAIT.
REQ-020 When the counter reaches TIMEOUT_CYC without progress, the block shall go to DONE with WData_WB=0 and WRegEn_WB=0, and set err_o.
REQ-021 If gnt or rvalid coincides with the timeout cycle, the handshake shall win and no error shall be raised.
REQ-022 err_o shall stay set until reset.

Reset
REQ-023 When rst=0 at a clock edge: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, WRegEn_WB=0, WReg1_WB=0, WData_WB=0, err_o=0, counter=0.
REQ-024 Reset mid-operation shall discard the in-flight op with no WB pulse; a late gnt or rvalid after reset shall be ignored.

Configuration
REQ-025 With macro MEM_STAGE_PERF_CNT_EN defined, the block shall add output stall_cnt (32 bits): it counts cycles with stall_M=1, resets to 0, and saturates at all-ones.
REQ-026 Without MEM_STAGE_PERF_CNT_EN, the port and counter shall be absent and all other behaviour shall be identical.

Structure
REQ-027 A shared package mem_stage_pkg shall hold the FSM state enum, the default widths and TIMEOUT_CYC default.
REQ-028 The wait/timeout counter shall be one sub-module, mem_stage_timer (inputs clear and enable; output expired).

Verification
REQ-029 Store addr=0x12, data=0xDEADBEEF_00000001, gnt in first REQ cycle -> dmem_we=1, stall_M high for 2 cycles, no WRegEn_WB, done in cycle 3.
REQ-030 Load addr=0x34, WReg1=5, gnt after 2 cycles, rvalid 3 cycles later with data 0x0123 -> WRegEn_WB=1 for one cycle, WReg1_WB=5, WData_WB=0x0123.
REQ-031 Load with no gnt for 15 cycles -> DONE, WRegEn_WB=0, WData_WB=0, err_o=1 and still 1 after 10 further idle cycles.
REQ-032 gnt arriving exactly at cycle 15 -> normal completion, err_o=0.
REQ-033 rst=0 while in RWAIT, then rvalid -> no WB pulse, state IDLE, all outputs 0.
REQ-034 Back-to-back store then load with gnt and rvalid immediate -> each op completes exactly once; with MEM_STAGE_PERF_CNT_EN, stall_cnt=5.
